// File: rtl/mcu1_pkg.sv
// Shared definitions for the mcu1 accumulator core: opcodes, FSM states
// and instruction field geometry as a function of the data width.
package mcu1_pkg;

    // Width of the opcode field at the top of every instruction word.
    localparam int unsigned OP_W = 4;

    typedef enum logic [3:0] {
        OP_LD   = 4'h0,
        OP_ADD  = 4'h1,
        OP_JMP  = 4'h2,
        OP_ST   = 4'h3,
        OP_CMP  = 4'h4,
        OP_JEQ  = 4'h5,
        OP_SUB  = 4'h6,
        OP_AND  = 4'h7,
        OP_OR   = 4'h8,
        OP_XOR  = 4'h9,
        OP_JLT  = 4'hA,
        OP_LDI  = 4'hB,
        OP_NOPC = 4'hC,
        OP_NOPD = 4'hD,
        OP_NOPE = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // Lowest bit index of the opcode field for a w-bit instruction.
    function automatic int unsigned op_lsb(input int unsigned w);
        return w - OP_W;
    endfunction

    // Width of the constant/address field for a w-bit instruction.
    function automatic int unsigned c_width(input int unsigned w);
        return w - OP_W;
    endfunction

endpackage

// File: rtl/mcu1_alu.sv
// Combinational ALU: result and N/Z status for the accumulator operations.
// CMP reports a true signed comparison rather than the sign of a-b, so it
// stays correct when the subtraction would overflow.
module mcu1_alu
    import mcu1_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  opcode_t      op,
    output logic [W-1:0] y,
    output logic         n,
    output logic         z
);

    // Result selection and flag derivation.
    always_comb begin
        y = a;
        unique case (op)
            OP_ADD:         y = a + b;
            OP_SUB, OP_CMP: y = a - b;
            OP_AND:         y = a & b;
            OP_OR:          y = a | b;
            OP_XOR:         y = a ^ b;
            default:        y = a;
        endcase
        n = y[W-1];
        z = (y == '0);
        if (op == OP_CMP) begin
            n = ($signed(a) < $signed(b));
            z = (a == b);
        end
    end

endmodule

// File: rtl/mcu1_core.sv
// mcu1 multicycle accumulator core: FETCH/EXEC/MEM/HALT state machine with
// a req/ack memory port that tolerates wait states. All memory-port outputs
// are registered; the next transaction is set up at the edge that ends the
// current state so zero-wait memory sees back-to-back requests.
module mcu1_core
    import mcu1_pkg::*;
#(
    parameter  int unsigned W        = 16,
    parameter  int unsigned RESET_PC = 0,
    localparam int unsigned AW       = c_width(W)
) (
    input  logic          clock,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [W-1:0]  mem_wdata,
    input  logic          mem_ack,
    input  logic [W-1:0]  mem_rdata,
    output logic [AW-1:0] pc,
    output logic [W-1:0]  acc,
    output logic          flag_n,
    output logic          flag_z,
    output logic          halted
);

    localparam int unsigned OP_LSB = op_lsb(W);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [W-1:0]  ir_q, ir_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          n_q, n_d;
    logic          z_q, z_d;
    logic          halted_q, halted_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [W-1:0]  wdata_q, wdata_d;

    opcode_t       opc;
    logic [AW-1:0] cfield;
    logic [AW-1:0] jump_pc;
    logic [W-1:0]  alu_y;
    logic          alu_n;
    logic          alu_z;

    assign opc    = opcode_t'(ir_q[OP_LSB +: OP_W]);
    assign cfield = ir_q[AW-1:0];

    mcu1_alu #(
        .W (W)
    ) u_alu (
        .a  (acc_q),
        .b  (mem_rdata),
        .op (opc),
        .y  (alu_y),
        .n  (alu_n),
        .z  (alu_z)
    );

    // Next-state logic for the FSM, architectural state and memory port.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        acc_d    = acc_q;
        n_d      = n_q;
        z_d      = z_q;
        halted_d = halted_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        jump_pc  = pc_q;

        unique case (state_q)
            S_FETCH: begin
                if (!req_q) begin
                    // Only reached straight out of reset: raise the first fetch.
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q;
                end else if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + AW'(1);
                    req_d   = 1'b0;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                unique case (opc)
                    OP_HALT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_ST: begin
                        state_d = S_MEM;
                        req_d   = 1'b1;
                        we_d    = (opc == OP_ST);
                        addr_d  = cfield;
                        wdata_d = acc_q;
                    end
                    default: begin
                        // Jumps, LDI and NOPs finish here and launch the next fetch.
                        if (opc == OP_JMP || (opc == OP_JEQ && z_q) || (opc == OP_JLT && n_q)) begin
                            jump_pc = cfield;
                        end
                        if (opc == OP_LDI) begin
                            acc_d = W'(cfield);
                        end
                        pc_d    = jump_pc;
                        state_d = S_FETCH;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = jump_pc;
                    end
                endcase
            end

            S_MEM: begin
                if (mem_ack) begin
                    unique case (opc)
                        OP_LD: begin
                            acc_d = mem_rdata;
                        end
                        OP_CMP: begin
                            n_d = alu_n;
                            z_d = alu_z;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            acc_d = alu_y;
                            n_d   = alu_n;
                            z_d   = alu_z;
                        end
                        default: begin
                            acc_d = acc_q;
                        end
                    endcase
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = pc_q;
                end
            end

            S_HALT: begin
                req_d = 1'b0;
            end
        endcase
    end

    // State register; reset clears the port asynchronously so a store in
    // flight is abandoned before any further edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= AW'(RESET_PC);
            ir_q     <= '0;
            acc_q    <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            halted_q <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            acc_q    <= acc_d;
            n_q      <= n_d;
            z_q      <= z_d;
            halted_q <= halted_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign pc        = pc_q;
    assign acc       = acc_q;
    assign flag_n    = n_q;
    assign flag_z    = z_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_mcu1_core.sv
// Directed self-checking bench for mcu1_core: a W=16 instance with an
// optional random-wait memory and a W=12 instance with zero-wait memory.
module tb_mcu1_core;

    logic clock;
    logic reset16, reset12;

    logic        req16, we16, ack16, n16, z16, halted16;
    logic [11:0] addr16, pc16;
    logic [15:0] wdata16, rdata16, acc16;

    logic        req12, we12, ack12, n12, z12, halted12;
    logic [7:0]  addr12, pc12;
    logic [11:0] wdata12, rdata12, acc12;

    logic [15:0] mem16 [0:4095];
    logic [11:0] mem12 [0:255];

    int   max_wait;
    int   wait16;
    logic spur16;
    int   total;
    int   bad;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign ack16   = (req16 && (wait16 == 0)) || spur16;
    assign rdata16 = mem16[addr16];
    assign ack12   = req12;
    assign rdata12 = mem12[addr12];

    // Per-transaction wait-state counter for the W=16 memory.
    always @(posedge clock or posedge reset16) begin
        if (reset16)              wait16 <= 0;
        else if (!req16 || ack16) wait16 <= $urandom_range(0, max_wait);
        else if (wait16 > 0)      wait16 <= wait16 - 1;
    end

    mcu1_core #(.W(16), .RESET_PC(0)) u_core16 (
        .clock(clock), .reset(reset16),
        .mem_req(req16), .mem_we(we16), .mem_addr(addr16), .mem_wdata(wdata16),
        .mem_ack(ack16), .mem_rdata(rdata16),
        .pc(pc16), .acc(acc16), .flag_n(n16), .flag_z(z16), .halted(halted16)
    );

    mcu1_core #(.W(12), .RESET_PC(8'hFC)) u_core12 (
        .clock(clock), .reset(reset12),
        .mem_req(req12), .mem_we(we12), .mem_addr(addr12), .mem_wdata(wdata12),
        .mem_ack(ack12), .mem_rdata(rdata12),
        .pc(pc12), .acc(acc12), .flag_n(n12), .flag_z(z12), .halted(halted12)
    );

    // One clock: capture store commits before the edge, apply them after, sample at +1.
    task automatic cycle();
        logic        w16, w12;
        logic [11:0] a16;
        logic [15:0] d16;
        logic [7:0]  a12;
        logic [11:0] d12;
        @(negedge clock);
        w16 = req16 && we16 && ack16; a16 = addr16; d16 = wdata16;
        w12 = req12 && we12 && ack12; a12 = addr12; d12 = wdata12;
        @(posedge clock);
        if (w16) mem16[a16] = d16;
        if (w12) mem12[a12] = d12;
        #1;
    endtask

    task automatic load_sum16();
        for (int i = 0; i < 4096; i++) mem16[i] = '0;
        mem16[12'h000] = 16'hB000; // LDI 0
        mem16[12'h001] = 16'h3020; // ST  sum
        mem16[12'h002] = 16'hB001; // LDI 1
        mem16[12'h003] = 16'h3021; // ST  i
        mem16[12'h004] = 16'h0020; // LD  sum
        mem16[12'h005] = 16'h1021; // ADD i
        mem16[12'h006] = 16'h3020; // ST  sum
        mem16[12'h007] = 16'h0021; // LD  i
        mem16[12'h008] = 16'h4023; // CMP ten
        mem16[12'h009] = 16'h500E; // JEQ done
        mem16[12'h00A] = 16'h1022; // ADD one
        mem16[12'h00B] = 16'h3021; // ST  i
        mem16[12'h00C] = 16'h2004; // JMP loop
        mem16[12'h00D] = 16'hC000; // NOP
        mem16[12'h00E] = 16'hF000; // HALT
        mem16[12'h022] = 16'h0001;
        mem16[12'h023] = 16'h000A;
    endtask

    task automatic load_flags16();
        for (int i = 0; i < 4096; i++) mem16[i] = '0;
        mem16[12'h000] = 16'hB005; // LDI 5
        mem16[12'h001] = 16'h4030; // CMP M[0x30]=7
        mem16[12'h002] = 16'h5010; // JEQ 0x10 (not taken)
        mem16[12'h003] = 16'hA008; // JLT 0x08 (taken)
        mem16[12'h004] = 16'hF000; // HALT
        mem16[12'h008] = 16'hB7FF; // LDI 0x7FF
        mem16[12'h009] = 16'hF000; // HALT
        mem16[12'h010] = 16'hB123; // LDI 0x123
        mem16[12'h011] = 16'hF000; // HALT
        mem16[12'h030] = 16'h0007;
    endtask

    task automatic test_reset();
        load_flags16();
        max_wait = 0;
        reset16 = 1'b1;
        cycle();
        total++; if (req16 !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", req16); end
        total++; if (pc16 !== 12'h000) begin bad++; $display("FAIL reset_pc: got %h want 000", pc16); end
        total++; if ({acc16, n16, z16, halted16} !== 19'h0) begin bad++; $display("FAIL reset_state: got acc=%h n=%b z=%b h=%b want zeros", acc16, n16, z16, halted16); end
        reset16 = 1'b0;
        cycle();
        total++; if ({req16, we16, addr16} !== {1'b1, 1'b0, 12'h000}) begin bad++; $display("FAIL first_fetch: got req=%b we=%b addr=%h want 1 0 000", req16, we16, addr16); end
        cycle();
        total++; if ({req16, pc16} !== {1'b0, 12'h001}) begin bad++; $display("FAIL exec_state: got req=%b pc=%h want 0 001", req16, pc16); end
        cycle();
        total++; if ({acc16, req16, addr16} !== {16'h0005, 1'b1, 12'h001}) begin bad++; $display("FAIL ldi_latency: got acc=%h req=%b addr=%h want 0005 1 001", acc16, req16, addr16); end
        #2 reset16 = 1'b1;
        #1;
        total++; if (req16 !== 1'b0) begin bad++; $display("FAIL async_req_drop: got %b want 0", req16); end
        total++; if ({pc16, acc16, halted16} !== 29'h0) begin bad++; $display("FAIL async_reset_state: got pc=%h acc=%h h=%b want zeros", pc16, acc16, halted16); end
        cycle();
        reset16 = 1'b0;
        cycle();
        total++; if ({req16, addr16} !== {1'b1, 12'h000}) begin bad++; $display("FAIL refetch: got req=%b addr=%h want 1 000", req16, addr16); end
    endtask

    task automatic test_sum_loop();
        int n;
        load_sum16();
        max_wait = 0;
        reset16 = 1'b1;
        cycle();
        reset16 = 1'b0;
        n = 0;
        while (!halted16 && n < 5000) begin cycle(); n++; end
        total++; if (halted16 !== 1'b1) begin bad++; $display("FAIL sum_halted: got %b want 1", halted16); end
        total++; if (n !== 255) begin bad++; $display("FAIL sum_cycles: got %0d want 255", n); end
        total++; if (mem16[12'h020] !== 16'h0037) begin bad++; $display("FAIL sum_result: got %h want 0037", mem16[12'h020]); end
        total++; if (pc16 !== 12'h00F) begin bad++; $display("FAIL sum_pc: got %h want 00F", pc16); end
        total++; if ({acc16, n16, z16} !== {16'h000A, 1'b0, 1'b1}) begin bad++; $display("FAIL sum_acc_flags: got acc=%h n=%b z=%b want 000A 0 1", acc16, n16, z16); end
    endtask

    task automatic test_wait_states();
        int          n;
        int          stalls;
        logic        pend, pw;
        logic [11:0] pa;
        logic [15:0] pd;
        load_sum16();
        max_wait = 3;
        reset16 = 1'b1;
        cycle();
        reset16 = 1'b0;
        n = 0; stalls = 0; pend = 1'b0; pw = 1'b0; pa = '0; pd = '0;
        while (!halted16 && n < 5000) begin
            cycle(); n++;
            if (pend) begin
                total++;
                if (!req16 || addr16 !== pa || we16 !== pw || wdata16 !== pd) begin
                    bad++;
                    $display("FAIL hold_stable: got req=%b addr=%h we=%b wd=%h want 1 %h %b %h", req16, addr16, we16, wdata16, pa, pw, pd);
                end
            end
            pend = req16 && !ack16;
            pa = addr16; pw = we16; pd = wdata16;
            if (pend) stalls++;
        end
        max_wait = 0;
        total++; if (halted16 !== 1'b1) begin bad++; $display("FAIL wait_halted: got %b want 1", halted16); end
        total++; if (stalls <= 0) begin bad++; $display("FAIL wait_seen: got %0d stalls want >0", stalls); end
        total++; if (mem16[12'h020] !== 16'h0037) begin bad++; $display("FAIL wait_result: got %h want 0037", mem16[12'h020]); end
        total++; if (pc16 !== 12'h00F) begin bad++; $display("FAIL wait_pc: got %h want 00F", pc16); end
    endtask

    task automatic test_flags();
        load_flags16();
        max_wait = 0;
        reset16 = 1'b1;
        cycle();
        reset16 = 1'b0;
        for (int i = 0; i < 200 && !halted16; i++) cycle();
        total++; if (halted16 !== 1'b1) begin bad++; $display("FAIL flags_halted: got %b want 1", halted16); end
        total++; if (pc16 !== 12'h00A) begin bad++; $display("FAIL branch_path: got pc=%h want 00A", pc16); end
        total++; if (acc16 !== 16'h07FF) begin bad++; $display("FAIL ldi_7ff: got %h want 07FF", acc16); end
        total++; if ({n16, z16} !== 2'b10) begin bad++; $display("FAIL cmp_flags: got n=%b z=%b want 1 0", n16, z16); end
    endtask

    task automatic test_spurious_ack();
        spur16 = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        spur16 = 1'b0;
        cycle();
        total++; if ({halted16, req16} !== 2'b10) begin bad++; $display("FAIL spur_halt: got h=%b req=%b want 1 0", halted16, req16); end
        total++; if ({pc16, acc16} !== {12'h00A, 16'h07FF}) begin bad++; $display("FAIL spur_state: got pc=%h acc=%h want 00A 07FF", pc16, acc16); end
        total++; if ({n16, z16} !== 2'b10) begin bad++; $display("FAIL spur_flags: got n=%b z=%b want 1 0", n16, z16); end
    endtask

    task automatic test_wrap_w12();
        logic       seen, prev_ff;
        for (int i = 0; i < 256; i++) mem12[i] = '0;
        mem12[8'hFC] = 12'h080; // LD  0x80
        mem12[8'hFD] = 12'h181; // ADD 0x81
        mem12[8'hFE] = 12'hC00; // NOP
        mem12[8'hFF] = 12'hE00; // NOP
        mem12[8'h00] = 12'hF00; // HALT
        mem12[8'h80] = 12'hFFF;
        mem12[8'h81] = 12'h001;
        total++; if (pc12 !== 8'hFC) begin bad++; $display("FAIL w12_reset_pc: got %h want FC", pc12); end
        reset12 = 1'b0;
        seen = 1'b0; prev_ff = 1'b0;
        for (int i = 0; i < 200 && !halted12; i++) begin
            cycle();
            if (req12 && !we12) begin
                if (prev_ff) begin
                    seen = 1'b1;
                    total++; if (addr12 !== 8'h00) begin bad++; $display("FAIL w12_pc_wrap: got %h want 00", addr12); end
                end
                prev_ff = (addr12 == 8'hFF);
            end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL w12_fetch_ff: got %b want 1", seen); end
        total++; if (halted12 !== 1'b1) begin bad++; $display("FAIL w12_halted: got %b want 1", halted12); end
        total++; if ({acc12, n12, z12} !== {12'h000, 1'b0, 1'b1}) begin bad++; $display("FAIL w12_add_wrap: got acc=%h n=%b z=%b want 000 0 1", acc12, n12, z12); end
        total++; if (pc12 !== 8'h01) begin bad++; $display("FAIL w12_final_pc: got %h want 01", pc12); end
    endtask

    initial begin
        total = 0; bad = 0;
        max_wait = 0; spur16 = 1'b0;
        reset16 = 1'b1; reset12 = 1'b1;
        for (int i = 0; i < 256; i++) mem12[i] = '0;
        test_reset();
        test_sum_loop();
        test_wait_states();
        test_flags();
        test_spurious_ack();
        test_wrap_w12();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mcu1_core.md
# mcu1_core

Parametrised multicycle accumulator CPU core, the next generation of the mcu0 datapath. It adds a fetch/execute state machine, a req/ack memory handshake tolerant of wait states, N/Z status flags, and an extended opcode set. It sits between the testbench/system top and a single shared instruction+data memory model.

## Interface
Parameters:
- W, 16: data and instruction width; legal range 8..32.
- RESET_PC, 0: PC value after reset.
- Derived localparam AW = W-4: address/constant field width.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; forces all state to reset values immediately.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  AW  word address; valid while mem_req=1.
- mem_wdata  out  W  write data; equals acc during a store.
- mem_ack  in  1  transaction complete; sampled at posedge only while mem_req=1.
- mem_rdata  in  W  read data; valid in the cycle mem_ack=1.
- pc  out  AW  program counter (observation).
- acc  out  W  accumulator (observation).
- flag_n, flag_z  out  1 each  status flags.
- halted  out  1  core stopped on HALT.

## Operation
- Memory is word-addressed: one W-bit word per address; PC increments by 1.
- Instruction format: OP = ir[W-1:W-4], C = ir[AW-1:0].
- Opcodes: LD=0 (acc=M[C]), ADD=1, JMP=2 (pc=C), ST=3 (M[C]=acc), CMP=4, JEQ=5 (pc=C if Z), SUB=6, AND=7, OR=8, XOR=9, JLT=A (pc=C if N), LDI=B (acc=zero-extended C), HALT=F. Opcodes C, D, E are NOPs.
- Flags:
  - CMP: N = (signed acc < signed M), Z = (acc == M); acc unchanged.
  - ADD/SUB/AND/OR/XOR: N = result[W-1], Z = (result == 0).
  - All other opcodes leave the flags unchanged.
- Arithmetic is modulo 2^W; there is no carry or overflow flag.
- PC wraps from 2^AW-1 to 0.
- FSM states:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ack: ir <= mem_rdata, pc <= pc+1, go to EXEC.
  - EXEC: decode ir.
    - Jumps, LDI, and NOPs complete here; go to FETCH.
    - HALT: go to HALT.
    - LD/ADD/SUB/AND/OR/XOR/CMP/ST: go to MEM.
  - MEM: mem_req=1, mem_addr=C, mem_we=(OP==ST). On ack: perform the read op or complete the store, then go to FETCH. Until ack, stay in MEM with outputs stable.
  - HALT: mem_req=0, halted=1. Only reset leaves this state.
- Handshake:
  - Address, we, and wdata are held stable from req rise until the ack cycle inclusive.
  - mem_req deasserts, or moves to the next transaction, on the cycle after ack.
  - Ack arriving while req=0 is ignored.
  - Zero-wait memory (ack high in the same cycle as req) is legal.
- Reset values: pc=RESET_PC, acc=0, ir=0, flag_n=0, flag_z=0, halted=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, state=FETCH.
- Reset mid-transaction: mem_req drops asynchronously. A store in flight is abandoned; the memory must not commit it without an ack at a posedge.

## Timing
- Zero-wait memory gives these latencies (clocks per instruction):
  - JMP/JEQ/JLT/LDI/NOP: 2.
  - LD/ST/ALU/CMP: 3.
  - HALT: halted asserts 2 cycles after fetch start.
- Each memory wait cycle adds exactly 1 cycle.
- Branch decisions use the flag values registered before EXEC.
- A CMP immediately followed by JEQ sees the CMP result.
- acc, flags, and pc update at the posedge that ends the state executing them.

## Structure
- Package mcu1_pkg holds the opcode enum (4-bit), the FSM state enum, and field-extraction constants for OP and C as functions of W.
- Sub-module mcu1_alu: combinational; inputs a, b, op; outputs y, n, z.
- The core holds the FSM, PC, IR, and ACC.

## Test plan
- Reset: assert reset mid-FETCH with mem_req=1. Expected: mem_req=0 immediately; pc=0, acc=0, halted=0; fetch restarts at 0 after release.
- Sum loop, W=16, zero-wait memory: program computes 1+2+…+10 into M[0x20] via LD/ADD/ST/CMP/JEQ/JMP, then HALT. Expected: M[0x20]=55 (0x0037); halted=1; pc = HALT address + 1.
- Wait states: same program with random 0–3 cycle ack delay. Expected: identical final memory; mem_addr, mem_we, and mem_wdata stable while req=1 without ack.
- Flags: acc=0x0005, CMP against M=0x0007. Expected: N=1, Z=0; JLT taken; JEQ not taken.
- Wrap and width: W=12 (AW=8), ADD 0xFFF + 0x001. Expected: acc=0x000, Z=1, N=0. pc=0xFF executing a NOP fetches next from 0x00.
- Spurious ack: pulse mem_ack while in HALT. Expected: no state change; LDI 0x7FF at W=16 gives acc=0x07FF.
